// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter.
// Optional stats counters are enabled by FIFO_WR_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_t;

  localparam int PKT_CNT_WIDTH = 16;

  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side bus of the write arbiter.
// pkt_count exists only with FIFO_WR_ARB_STATS_EN.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int GW    = fifo_arb_pkg::id_width(N_REQ)
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       fifo_data;
  logic                   fifo_wr_en;
  logic                   fifo_full;
  logic [GW-1:0]          grant_id;
  logic                   busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ*16-1:0]    pkt_count;
`endif

  modport master (
    output req_valid, req_last, req_data,
    output fifo_full,
    input  req_ready, fifo_data, fifo_wr_en,
`ifdef FIFO_WR_ARB_STATS_EN
    input  pkt_count,
`endif
    input  grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data,
    input  fifo_full,
    output req_ready, fifo_data, fifo_wr_en,
`ifdef FIFO_WR_ARB_STATS_EN
    output pkt_count,
`endif
    output grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_core.sv
// Packet-locking arbiter FSM driving the FIFO write bus.
// Stats counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter_core
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 16,
  localparam int GW    = id_width(N_REQ)
) (
  input logic           i_clk,
  input logic           i_rst,
  fifo_wr_arbiter_if.slave bus
);

  arb_state_t    state, state_nx;
  logic [GW-1:0] grant, last_grant, winner;
  logic          any_req, lock, beat, done;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Reset gates the grant off before the register settles.
  assign lock = (state == ARB_LOCK) && !i_rst;
  assign beat = lock && bus.req_valid[grant]
              && !bus.fifo_full;
  assign done = beat && bus.req_last[grant];

  assign bus.fifo_wr_en = beat;
  assign bus.busy       = lock;
  assign bus.grant_id   = grant;
  assign bus.fifo_data  =
    bus.req_data[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    bus.req_ready = '0;
    if (lock) bus.req_ready[grant] = !bus.fifo_full;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: if (any_req) state_nx = ARB_LOCK;
      ARB_LOCK: if (done)    state_nx = ARB_IDLE;
      default:               state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= GW'(N_REQ - 1);
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && any_req) grant <= winner;
      if (done) last_grant <= grant;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ-1:0][PKT_CNT_WIDTH-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (done && cnt[grant] != '1) begin
      cnt[grant] <= cnt[grant] + 1'b1;
    end
  end

  assign bus.pkt_count = cnt;
`endif

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first requester above last_grant, wrapping.
// Purely combinational.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int GW    = fifo_arb_pkg::id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    winner,
  output logic             any_req
);

  int idx;

  // Scan from lowest priority up so the highest-priority hit lands last.
  always_comb begin
    winner  = '0;
    any_req = |req;
    idx     = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (req[idx]) winner = GW'(idx);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin write arbiter in front of a sync FIFO.
// Define FIFO_WR_ARB_STATS_EN for per-requester packet counters.
module fifo_wr_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 16,
  localparam int GW    = fifo_arb_pkg::id_width(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ-1:0]       i_req_last,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]       o_fifo_data,
  output logic                   o_fifo_wr_en,
  input  logic                   i_fifo_full,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [N_REQ*16-1:0]    o_pkt_count,
`endif
  output logic [GW-1:0]          o_grant_id,
  output logic                   o_busy
);

  fifo_wr_arbiter_if #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) bus ();

  assign bus.req_valid = i_req_valid;
  assign bus.req_last  = i_req_last;
  assign bus.req_data  = i_req_data;
  assign bus.fifo_full = i_fifo_full;

  assign o_req_ready  = bus.req_ready;
  assign o_fifo_data  = bus.fifo_data;
  assign o_fifo_wr_en = bus.fifo_wr_en;
  assign o_grant_id   = bus.grant_id;
  assign o_busy       = bus.busy;
`ifdef FIFO_WR_ARB_STATS_EN
  assign o_pkt_count  = bus.pkt_count;
`endif

  fifo_wr_arbiter_core #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic
// against a packet-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int GW = 2;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (bus.req_valid),
    .i_req_last   (bus.req_last),
    .i_req_data   (bus.req_data),
    .o_req_ready  (bus.req_ready),
    .o_fifo_data  (bus.fifo_data),
    .o_fifo_wr_en (bus.fifo_wr_en),
    .i_fifo_full  (bus.fifo_full),
`ifdef FIFO_WR_ARB_STATS_EN
    .o_pkt_count  (bus.pkt_count),
`endif
    .o_grant_id   (bus.grant_id),
    .o_busy       (bus.busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: packet-level view of who owns the FIFO.
  bit m_lock;
  int m_g;
  int m_last;
  int m_cnt[N];
  int wr_cycles;
  int gq[$];

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic [N-1:0] v, logic [N-1:0] l,
                       logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_full = f;
  endtask

  task automatic set_data(int r, logic [W-1:0] d);
    bus.req_data[r*W +: W] = d;
  endtask

  task automatic step();
    logic [N-1:0] e_rdy;
    logic         e_wr;
    logic         e_busy;
    @(negedge i_clk);
    e_rdy  = '0;
    e_wr   = 1'b0;
    e_busy = 1'b0;
    if (!i_rst && m_lock) begin
      e_busy = 1'b1;
      if (!bus.fifo_full) e_rdy[m_g] = 1'b1;
      e_wr = bus.req_valid[m_g] && !bus.fifo_full;
    end
    chk("ready", 64'(bus.req_ready), 64'(e_rdy));
    chk("wr_en", 64'(bus.fifo_wr_en), 64'(e_wr));
    chk("busy", 64'(bus.busy), 64'(e_busy));
    if (!i_rst) chk("grant", 64'(bus.grant_id), 64'(m_g));
    if (e_wr) begin
      chk("data", 64'(bus.fifo_data),
          64'(bus.req_data[m_g*W +: W]));
    end
`ifdef FIFO_WR_ARB_STATS_EN
    if (!i_rst) begin
      for (int r = 0; r < N; r++)
        chk("pkt_cnt", 64'(bus.pkt_count[r*16 +: 16]),
            64'(m_cnt[r]));
    end
`endif
    if (bus.fifo_wr_en) begin
      wr_cycles++;
      gq.push_back(int'(bus.grant_id));
    end
    if (i_rst) begin
      m_lock = 1'b0;
      m_g    = 0;
      m_last = N - 1;
      foreach (m_cnt[r]) m_cnt[r] = 0;
    end else if (m_lock) begin
      if (e_wr && bus.req_last[m_g]) begin
        m_last = m_g;
        m_lock = 1'b0;
        if (m_cnt[m_g] < 16'hFFFF) m_cnt[m_g]++;
      end
    end else if (|bus.req_valid) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (bus.req_valid[c]) begin
          m_g = c;
          break;
        end
      end
      m_lock = 1'b1;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive('0, '0, 1'b0);
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    bus.req_data = '0;
    m_lock = 1'b0;
    m_g    = 0;
    m_last = N - 1;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    do_reset();
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);

    // Single requester, three-beat packet.
    wr_cycles = 0;
    drive(4'b0001, 4'b0000, 1'b0);
    set_data(0, 16'h0001);
    step();
    chk("s1_grant", 64'(bus.grant_id), 64'd0);
    step();
    set_data(0, 16'h0002);
    step();
    set_data(0, 16'h0003);
    drive(4'b0001, 4'b0001, 1'b0);
    step();
    drive('0, '0, 1'b0);
    step();
    chk("s1_beats", 64'(wr_cycles), 64'd3);
    chk("s1_busy", 64'(bus.busy), 64'd0);

    // Everyone sends one-beat packets back to back.
    do_reset();
    gq.delete();
    drive(4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("rr_n", 64'(gq.size()), 64'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk("rr_order", 64'(gq[i]), 64'(i % N));

    // FIFO full for five cycles during beat 2 of 4.
    do_reset();
    wr_cycles = 0;
    drive(4'b0001, 4'b0000, 1'b0);
    set_data(0, 16'hA001);
    step();
    step();
    set_data(0, 16'hA002);
    drive(4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("full_hold", 64'(wr_cycles), 64'd1);
    drive(4'b0001, 4'b0000, 1'b0);
    step();
    set_data(0, 16'hA003);
    step();
    set_data(0, 16'hA004);
    drive(4'b0001, 4'b0001, 1'b0);
    step();
    chk("full_done", 64'(wr_cycles), 64'd4);

    // Locked requester stalls; the other must wait.
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0);
    step();
    step();
    drive(4'b0100, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("stall_grant", 64'(bus.grant_id), 64'd1);
    drive(4'b0110, 4'b0110, 1'b0);
    step();
    drive(4'b0100, 4'b0100, 1'b0);
    step();
    chk("stall_next", 64'(bus.grant_id), 64'd2);
    step();

    // Reset in the middle of a packet.
    do_reset();
    drive(4'b1000, 4'b0000, 1'b0);
    step();
    step();
    i_rst = 1'b1;
    drive(4'b1001, 4'b0000, 1'b0);
    step();
    i_rst = 1'b0;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    step();
    chk("rst_mid_win", 64'(bus.grant_id), 64'd0);
    step();

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    drive(4'b0100, 4'b0100, 1'b0);
    for (int i = 0; i < 10; i++) step();
    drive('0, '0, 1'b0);
    step();
    for (int r = 0; r < N; r++)
      chk("stats5", 64'(bus.pkt_count[r*16 +: 16]),
          64'((r == 2) ? 5 : 0));
`endif

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      i_rst = ($urandom_range(99) == 0);
      for (int r = 0; r < N; r++) begin
        bus.req_valid[r] = ($urandom_range(9) < 6);
        bus.req_last[r]  = ($urandom_range(9) < 3);
        set_data(r, 16'($urandom));
      end
      bus.fifo_full = ($urandom_range(9) < 2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 1..16.
REQ-002 SHALL have parameter WIDTH, default 16: data width, matching the downstream sync FIFO.
REQ-003 SHALL have port i_clk, input, 1: clock.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_req_valid, input, N_REQ: per-requester beat valid.
REQ-006 SHALL have port i_req_last, input, N_REQ: per-requester last beat of packet.
REQ-007 SHALL have port i_req_data, input, N_REQ*WIDTH: requester r occupies bits [r*WIDTH +: WIDTH].
REQ-008 SHALL have port o_req_ready, output, N_REQ: per-requester beat accepted.
REQ-009 SHALL have port o_fifo_data, output, WIDTH: data to the FIFO write bus.
REQ-010 SHALL have port o_fifo_wr_en, output, 1: FIFO write strobe.
REQ-011 SHALL have port i_fifo_full, input, 1: FIFO full flag.
REQ-012 SHALL have port o_grant_id, output, max(1,$clog2(N_REQ)): index of the granted requester.
REQ-013 SHALL have port o_busy, output, 1: high while a packet is locked.

Function
REQ-014 SHALL implement a two-state FSM, ARB_IDLE and ARB_LOCK.
REQ-015 In ARB_IDLE with any i_req_valid set, SHALL register the round-robin winner into o_grant_id and enter ARB_LOCK on the next edge: 1 cycle arbitration latency.
REQ-016 Round-robin SHALL give highest priority to (last_grant+1) mod N_REQ, searching upward with wrap from N_REQ-1 to 0; last_grant SHALL reset to N_REQ-1, so requester 0 wins first.
REQ-017 In ARB_LOCK, o_req_ready[g] SHALL equal !i_fifo_full, combinationally; all other ready bits SHALL be 0.
REQ-018 o_fifo_wr_en SHALL equal ARB_LOCK && i_req_valid[g] && !i_fifo_full; o_fifo_data SHALL be the granted requester's data slice, combinationally.
REQ-019 The arbiter SHALL never assert o_fifo_wr_en while i_fifo_full=1, so the FIFO never raises a write error.
REQ-020 A transfer with i_req_last[g]=1 SHALL update last_grant to g and return to ARB_IDLE: one idle bubble between packets.
REQ-021 If i_req_valid[g] drops mid-packet, the arbiter SHALL hold the grant in ARB_LOCK; there is no timeout.
REQ-022 A single-beat packet (valid & last on the first beat) SHALL complete in one ARB_LOCK cycle.
REQ-023 In ARB_IDLE, all o_req_ready bits and o_fifo_wr_en SHALL be 0.
REQ-024 o_busy SHALL be 1 exactly when in ARB_LOCK.

Reset
REQ-025 While i_rst=1, SHALL hold state=ARB_IDLE, o_grant_id=0, last_grant=N_REQ-1, o_busy=0, o_req_ready=0 and o_fifo_wr_en=0.
REQ-026 Reset mid-packet SHALL drop the grant immediately with no further writes; the partial packet is not recovered.

Configuration
REQ-027 With FIFO_WR_ARB_STATS_EN defined, SHALL add output o_pkt_count (N_REQ*16): per-requester completed-packet counters that increment on each last-beat transfer, saturate at 16'hFFFF and reset to 0.
REQ-028 Without FIFO_WR_ARB_STATS_EN, o_pkt_count and its counters SHALL not exist.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold typedef arb_state_t {ARB_IDLE, ARB_LOCK} and localparam PKT_CNT_WIDTH=16.
REQ-030 The round-robin priority pick SHALL be sub-module rr_pick: combinational, with inputs req and last_grant and outputs winner index and any_req.

Verification
REQ-031 Single requester: req0 sends 3 beats 0x0001..0x0003, last on the third -> o_grant_id=0 one cycle after valid; wr_en high for 3 consecutive cycles; o_busy falls after the third beat.
REQ-032 All 4 requesters continuously send 1-beat packets -> grant order 0,1,2,3,0; each packet takes 2 cycles (IDLE + LOCK).
REQ-033 Full mid-packet: i_fifo_full=1 for 5 cycles during beat 2 of 4 -> ready and wr_en stay 0 for those 5 cycles; data unchanged; packet then completes in order.
REQ-034 req1 locked with valid dropped for 3 cycles while req2 is valid -> grant stays 1; req2 granted only after req1's last beat.
REQ-035 i_rst pulsed during beat 2 of a req3 packet -> next cycle shows ARB_IDLE, wr_en=0, and requester 0 wins the next arbitration.
REQ-036 With FIFO_WR_ARB_STATS_EN: 5 packets from req2 -> o_pkt_count slice 2 = 5, other slices 0.
